// File: rtl/seg7_scroll_driver_pkg.sv
// Shared constants for the scrolling 7-segment driver:
// segment patterns, character field layout and a width helper.
package seg7_pkg;

  // Active-low {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_0 = 7'h01;
  localparam logic [6:0] SEG_1 = 7'h4F;
  localparam logic [6:0] SEG_2 = 7'h12;
  localparam logic [6:0] SEG_3 = 7'h06;
  localparam logic [6:0] SEG_4 = 7'h4C;
  localparam logic [6:0] SEG_5 = 7'h24;
  localparam logic [6:0] SEG_6 = 7'h20;
  localparam logic [6:0] SEG_7 = 7'h0F;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h04;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h60;
  localparam logic [6:0] SEG_C = 7'h31;
  localparam logic [6:0] SEG_D = 7'h42;
  localparam logic [6:0] SEG_E = 7'h30;
  localparam logic [6:0] SEG_F = 7'h38;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int CH_DP      = 5;
  localparam int CH_BLANK   = 4;
  localparam int CH_HEX_MSB = 3;
  localparam int CH_HEX_LSB = 0;

  localparam logic [5:0] CH_RESET = 6'b010000;

  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/seg7_scroll_driver_if.sv
// Host write port into the message buffer.
// The host side drives; the driver samples.
interface seg7_scroll_driver_if #(
  parameter int ADDR_W = 3
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [5:0]        wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/seg7_scroll_driver_decoder.sv
// Combinational {blank, hex} to active-low segment pattern.
// Blank wins over any hex value.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic       blank,
  input  logic [3:0] hex,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_BLANK;
    if (!blank) begin
      unique case (hex)
        4'h0: pattern = SEG_0;
        4'h1: pattern = SEG_1;
        4'h2: pattern = SEG_2;
        4'h3: pattern = SEG_3;
        4'h4: pattern = SEG_4;
        4'h5: pattern = SEG_5;
        4'h6: pattern = SEG_6;
        4'h7: pattern = SEG_7;
        4'h8: pattern = SEG_8;
        4'h9: pattern = SEG_9;
        4'hA: pattern = SEG_A;
        4'hB: pattern = SEG_B;
        4'hC: pattern = SEG_C;
        4'hD: pattern = SEG_D;
        4'hE: pattern = SEG_E;
        4'hF: pattern = SEG_F;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scroll_driver.sv
// Multiplexed common-anode driver showing a scrolling window
// of a host-written message buffer, with dead time and dimming.
module seg7_scroll_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int MSG_DEPTH     = 8,
  parameter int SLOT_CYCLES   = 32,
  parameter int DEAD_CYCLES   = 2,
  parameter int BRIGHT_W      = 4,
  parameter int SCROLL_FRAMES = 64,
  localparam int AW = clog2(MSG_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  seg7_scroll_driver_if.slave   wr,
  input  logic                  step,
  input  logic                  auto_scroll,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [AW-1:0]         offset
);

  localparam int SW = clog2(SLOT_CYCLES);
  localparam int IW = clog2(NUM_DIGITS);
  localparam int FW = clog2(SCROLL_FRAMES);

  logic [SW-1:0]       slot_cnt;
  logic [IW-1:0]       idx;
  logic [FW-1:0]       frame_cnt;
  logic [5:0]          mem [MSG_DEPTH];
  logic [5:0]          ch_q;
  logic [BRIGHT_W-1:0] bright_q;

  logic                slot_start;
  logic                slot_end;
  logic                frame_end;
  logic                auto_tick;
  logic [AW-1:0]       rd_addr;
  logic [5:0]          ch_eff;
  logic [BRIGHT_W-1:0] br_eff;
  logic [31:0]         sc32;
  logic [31:0]         hi32;
  logic                lit;
  logic [6:0]          pattern;

  assign slot_start = slot_cnt == '0;
  assign slot_end   = slot_cnt == SW'(SLOT_CYCLES - 1);
  assign frame_end  = slot_end && idx == IW'(NUM_DIGITS - 1);
  assign auto_tick  = auto_scroll && frame_end
                   && frame_cnt == FW'(SCROLL_FRAMES - 1);

  // Leftmost digit (highest idx) shows buffer[offset]
  assign rd_addr = offset + AW'(NUM_DIGITS - 1) - AW'(idx);

  // First cycle of a slot uses the fresh values so DEAD_CYCLES=0 works
  assign ch_eff = slot_start ? mem[rd_addr] : ch_q;
  assign br_eff = slot_start ? brightness : bright_q;

  assign sc32 = 32'(slot_cnt);
  assign hi32 = 32'(DEAD_CYCLES) + 32'(br_eff);
  assign lit  = !ch_eff[CH_BLANK]
             && sc32 >= 32'(DEAD_CYCLES)
             && sc32 < hi32;

  seg7_hex_decoder u_dec (
    .blank   (ch_eff[CH_BLANK]),
    .hex     (ch_eff[CH_HEX_MSB:CH_HEX_LSB]),
    .pattern (pattern)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_cnt  <= '0;
      idx       <= '0;
      frame_cnt <= '0;
      offset    <= '0;
      ch_q      <= CH_RESET;
      bright_q  <= '0;
      an        <= '1;
      seg       <= SEG_BLANK;
      dp        <= 1'b1;
      for (int i = 0; i < MSG_DEPTH; i++) mem[i] <= CH_RESET;
    end else begin
      slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
      if (slot_end)
        idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      if (slot_start) begin
        ch_q     <= mem[rd_addr];
        bright_q <= brightness;
      end
      if (step || auto_tick) offset <= offset + 1'b1;
      if (!auto_scroll)  frame_cnt <= '0;
      else if (frame_end)
        frame_cnt <= auto_tick ? '0 : frame_cnt + 1'b1;
      if (wr.wr_en) mem[wr.wr_addr] <= wr.wr_data;
      an  <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
      seg <= lit ? pattern : SEG_BLANK;
      dp  <= lit ? ~ch_eff[CH_DP] : 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scroll_driver.sv
// Directed bench for seg7_scroll_driver with hand-computed
// patterns; timing is tracked by counting clk edges since reset.
module tb_seg7_scroll_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       step = 1'b0;
  logic       auto_scroll = 1'b0;
  logic [3:0] brightness = 4'd15;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic [2:0] offset;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Offset 0 with entries 0..3 = 1,2,3,4 (dp on entry 2), by digit k
  logic [3:0] an_t  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] seg_t [4] = '{7'h4C, 7'h06, 7'h12, 7'h4F};
  logic       dp_t  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  seg7_scroll_driver_if #(.ADDR_W(3)) wr_bus ();

  seg7_scroll_driver #(
    .NUM_DIGITS    (4),
    .MSG_DEPTH     (8),
    .SLOT_CYCLES   (32),
    .DEAD_CYCLES   (2),
    .BRIGHT_W      (4),
    .SCROLL_FRAMES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr          (wr_bus),
    .step        (step),
    .auto_scroll (auto_scroll),
    .brightness  (brightness),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .offset      (offset)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s @cyc %0d: got %h expected %h",
             tag, cyc, got, exp);
    end
  endtask

  task automatic goto(input int n);
    if (cyc > n) chk("sched", cyc, n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [5:0] d);
    wr_bus.wr_en   = 1'b1;
    wr_bus.wr_addr = a;
    wr_bus.wr_data = d;
    @(negedge clk);
    wr_bus.wr_en   = 1'b0;
  endtask

  // One full frame; output at edge c reflects slot_cnt (c-1)%32
  task automatic check_frame(input int first, input int bright,
                             input bit blank);
    int  lows [4];
    int  sc, k;
    bit  on;
    for (int i = 0; i < 4; i++) lows[i] = 0;
    for (int c = first; c < first + 128; c++) begin
      goto(c);
      sc = (c - 1) % 32;
      k  = ((c - 1) / 32) % 4;
      on = !blank && sc >= 2 && sc < 2 + bright;
      chk("an",  an,  on ? an_t[k]  : 4'hF);
      chk("seg", seg, on ? seg_t[k] : 7'h7F);
      chk("dp",  dp,  on ? dp_t[k]  : 1'b1);
      if (an != 4'hF) lows[k]++;
    end
    for (int i = 0; i < 4; i++)
      chk("low_cnt", lows[i], blank ? 0 : bright);
  endtask

  task automatic pulse(input int n);
    goto(n);
    step = 1'b1;
    goto(n + 1);
    step = 1'b0;
  endtask

  initial begin
    wr_bus.wr_en   = 1'b0;
    wr_bus.wr_addr = '0;
    wr_bus.wr_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_off", offset, 3'd0);
    reset = 1'b0;

    // Blank buffer: no anode ever lit
    check_frame(1, 15, 1'b1);

    goto(130);
    wr(3'd0, 6'h01);
    wr(3'd1, 6'h02);
    wr(3'd2, 6'h23);
    wr(3'd3, 6'h04);
    check_frame(257, 15, 1'b0);

    goto(384);
    brightness = 4'd0;
    check_frame(385, 0, 1'b0);
    goto(512);
    brightness = 4'd1;
    check_frame(513, 1, 1'b0);

    for (int i = 0; i < 7; i++) pulse(641 + 2 * i);
    goto(655);
    chk("off_7", offset, 3'd7);
    pulse(655);
    chk("off_wrap", offset, 3'd0);

    auto_scroll = 1'b1;
    goto(895);
    step = 1'b1;
    chk("off_pre", offset, 3'd0);
    goto(896);
    step = 1'b0;
    chk("off_both", offset, 3'd1);

    // Window at offset 1: digit0 blank, digit1 '4', digit3 '2'
    goto(899);
    chk("w1_an0", an, 4'hF);
    goto(931);
    chk("w1_an1", an, 4'hD);
    chk("w1_seg1", seg, 7'h4C);
    goto(995);
    chk("w1_an3", an, 4'h7);
    chk("w1_seg3", seg, 7'h12);
    chk("w1_dp3", dp, 1'b1);

    goto(1151);
    chk("auto_pre", offset, 3'd1);
    goto(1152);
    chk("auto_1", offset, 3'd2);
    goto(2687);
    chk("auto_7", offset, 3'd7);
    goto(2688);
    chk("auto_wrap", offset, 3'd0);
    auto_scroll = 1'b0;
    goto(3000);
    chk("auto_off", offset, 3'd0);
    brightness = 4'd15;

    goto(3080);
    wr(3'd3, 6'h09);
    goto(3085);
    chk("old_an", an, 4'hE);
    chk("old_seg", seg, 7'h4C);
    goto(3203);
    chk("new_an", an, 4'hE);
    chk("new_seg", seg, 7'h04);
    goto(3210);
    chk("pre_rst_an", an, 4'hE);
    reset = 1'b1;
    #1;
    chk("mid_rst_an", an, 4'hF);
    chk("mid_rst_seg", seg, 7'h7F);
    chk("mid_rst_dp", dp, 1'b1);
    chk("mid_rst_off", offset, 3'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Buffer restored to blank
    check_frame(1, 15, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scroll_driver.md
Name: seg7_scroll_driver

Overview:
- Parametrised successor to the fixed four-digit multiplexed 7-segment driver.
- Drives NUM_DIGITS common-anode digits from an internal message buffer of MSG_DEPTH characters, which a host writes. A NUM_DIGITS-wide window is shown.
- The window scrolls on a debounced step pulse or automatically.
- Adds per-slot anode dead time (anti-ghosting), brightness control by on-time, a blank code, and a per-character decimal point.
- Sits between the debounce/clock-generation logic and the board pins, and replaces the fixed FSM-plus-decoder path.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- MSG_DEPTH, 8, message buffer entries (≥ NUM_DIGITS, power of two).
- SLOT_CYCLES, 32, clk cycles per digit slot.
- DEAD_CYCLES, 2, anode-off cycles at start of each slot.
- BRIGHT_W, 4, brightness input width; requires SLOT_CYCLES ≥ DEAD_CYCLES + 2^BRIGHT_W − 1.
- SCROLL_FRAMES, 64, full refresh frames per auto-scroll step.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous active-high reset.
- wr_en, in, 1, buffer write strobe.
- wr_addr, in, log2(MSG_DEPTH), buffer entry to write.
- wr_data, in, 6, {dp, blank, hex[3:0]}.
- step, in, 1, single-cycle debounced pulse; advances window by one.
- auto_scroll, in, 1, 1 = advance every SCROLL_FRAMES frames.
- brightness, in, BRIGHT_W, anode on-time in clk cycles per slot; 0 = dark.
- an, out, NUM_DIGITS, active-low anodes; an[0] is the rightmost digit.
- seg, out, 7, active-low {a,b,c,d,e,f,g}.
- dp, out, 1, active-low decimal point.
- offset, out, log2(MSG_DEPTH), current window start, for status/debug.

Behaviour:
- Reset values: an all 1s; seg 7'h7F; dp 1; slot_cnt 0; digit index 0; offset 0; frame counter 0; all buffer entries 6'b010000 (blank).
- Reset acts asynchronously; release takes effect on the next clk edge. Reset mid-slot forces all anodes off immediately.
- slot_cnt counts 0..SLOT_CYCLES−1 and wraps. On wrap, digit index increments modulo NUM_DIGITS. A frame is the wrap of digit index from NUM_DIGITS−1 to 0.
- Character selection: digit k shows buffer[(offset + NUM_DIGITS−1−k) mod MSG_DEPTH], so the leftmost digit shows buffer[offset].
- The character for the current digit is latched when slot_cnt == 0. Buffer writes and offset changes never alter a slot in progress; they are visible from the next slot.
- Decode: hex 0–F maps to standard segment patterns (0 = 7'h01, 8 = 7'h00, F = 7'h38). blank = 1 forces seg = 7'h7F regardless of hex. The dp bit is inverted onto the dp pin.
- Anode: an[idx] = 0 iff DEAD_CYCLES ≤ slot_cnt < DEAD_CYCLES + brightness; all other anodes stay 1.
  - brightness is sampled at slot_cnt == 0.
  - When the anode is off, seg and dp are driven to 1.
- All outputs are registered, so pins lag the slot_cnt condition by one cycle.
- Scroll:
  - A step pulse advances offset by 1 modulo MSG_DEPTH (MSG_DEPTH−1 wraps to 0).
  - With auto_scroll = 1, the frame counter counts frames. At SCROLL_FRAMES it advances offset and clears.
  - Step and auto tick in the same cycle advance offset by 1 only, and the frame counter clears.
  - auto_scroll = 0 holds the frame counter at 0.
- Buffer write: synchronous on clk when wr_en = 1. Writing the entry currently displayed takes effect at the next slot boundary.

Decomposition:
- Shared package seg7_pkg holds:
  - segment pattern constants SEG_0..SEG_F and SEG_BLANK;
  - the character field positions CH_DP = 5, CH_BLANK = 4, CH_HEX = 3:0;
  - a clog2 function.
- One sub-module: seg7_hex_decoder, combinational, {blank, hex} → 7-bit active-low pattern.

Test Plan (NUM_DIGITS = 4, MSG_DEPTH = 8, SLOT_CYCLES = 32, DEAD_CYCLES = 2, BRIGHT_W = 4, SCROLL_FRAMES = 2):
- Reset only, brightness = 15 → an = 4'hF, seg = 7'h7F, dp = 1 throughout. The four slots rotate with no anode ever low, because all entries are blank.
- Write entries 0..3 = hex 1,2,3,4 (dp set on entry 2), brightness = 15 → per frame, an = 1110 shows 4, 1101 shows 3 with dp = 0, 1011 shows 2, 0111 shows 1.
  - Each anode is low for exactly 15 cycles, starting 3 cycles after its slot start.
- brightness = 0 → an stays 4'hF. brightness = 1 → exactly 1 low cycle per slot.
- step pulse while offset = 7 → offset = 0. step and auto tick in the same cycle → offset advances by exactly 1.
- auto_scroll = 1, no steps → offset increments every 2 × 4 × 32 = 256 cycles and wraps 7 → 0.
- Write the displayed entry mid-slot, then assert reset mid-slot → the current slot shows the old value and the new value appears next slot. Reset drives an = 4'hF within the same cycle and restores the blank buffer.
